// File: rtl/sv32_tlb_pkg.sv
// rtl/sv32_tlb_pkg.sv - shared types and PTE bit positions for the SV32 TLB cache
package sv32_tlb_pkg;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_WALK = 2'd1,
    FL_DONE = 2'd2
  } fl_state_e;

  localparam int PTE_V_BIT      = 0;
  localparam int PTE_G_BIT_DFLT = 5;

endpackage

// File: rtl/sv32_tlb_cache_if.sv
// rtl/sv32_tlb_cache_if.sv - lookup/fill/flush bundle; SV32_TLB_STATS_EN adds hit/miss counters
interface sv32_tlb_cache_if #(
  parameter int VPN_WIDTH     = 20,
  parameter int ASID_WIDTH    = 9,
  parameter int PAYLOAD_WIDTH = 32
);
  logic                     lkp_valid;
  logic [VPN_WIDTH-1:0]     lkp_vpn;
  logic [ASID_WIDTH-1:0]    lkp_asid;
  logic                     lkp_hit;
  logic [PAYLOAD_WIDTH-1:0] lkp_pte;
  logic                     fill_valid;
  logic [VPN_WIDTH-1:0]     fill_vpn;
  logic [ASID_WIDTH-1:0]    fill_asid;
  logic [PAYLOAD_WIDTH-1:0] fill_pte;
  logic                     fl_req;
  logic                     fl_vpn_en;
  logic                     fl_asid_en;
  logic [VPN_WIDTH-1:0]     fl_vpn;
  logic [ASID_WIDTH-1:0]    fl_asid;
  logic                     fl_busy;
  logic                     fl_done;
`ifdef SV32_TLB_STATS_EN
  logic [31:0]              hit_cnt;
  logic [31:0]              miss_cnt;

  modport slave (
    input  lkp_valid, lkp_vpn, lkp_asid, fill_valid, fill_vpn, fill_asid, fill_pte,
    input  fl_req, fl_vpn_en, fl_asid_en, fl_vpn, fl_asid,
    output lkp_hit, lkp_pte, fl_busy, fl_done, hit_cnt, miss_cnt
  );
  modport master (
    output lkp_valid, lkp_vpn, lkp_asid, fill_valid, fill_vpn, fill_asid, fill_pte,
    output fl_req, fl_vpn_en, fl_asid_en, fl_vpn, fl_asid,
    input  lkp_hit, lkp_pte, fl_busy, fl_done, hit_cnt, miss_cnt
  );
`else
  modport slave (
    input  lkp_valid, lkp_vpn, lkp_asid, fill_valid, fill_vpn, fill_asid, fill_pte,
    input  fl_req, fl_vpn_en, fl_asid_en, fl_vpn, fl_asid,
    output lkp_hit, lkp_pte, fl_busy, fl_done
  );
  modport master (
    output lkp_valid, lkp_vpn, lkp_asid, fill_valid, fill_vpn, fill_asid, fill_pte,
    output fl_req, fl_vpn_en, fl_asid_en, fl_vpn, fl_asid,
    input  lkp_hit, lkp_pte, fl_busy, fl_done
  );
`endif
endinterface

// File: rtl/tlb_plru.sv
// rtl/tlb_plru.sv - per-set tree pseudo-LRU; each node bit points toward the victim half (1 = upper)
module tlb_plru #(
  parameter int SETS = 16,
  parameter int WAYS = 4,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr_all,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_set,
  input  logic [WAY_W-1:0] i_upd_way,
  input  logic [IDX_W-1:0] i_q_set,
  output logic [WAY_W-1:0] o_victim
);
  localparam int NODES = WAYS - 1;

  logic [NODES-1:0] r_tree [SETS];
  logic [NODES-1:0] w_upd_bits;
  logic [NODES-1:0] w_q_bits;

  // Heap-ordered nodes: level l holds nodes (1<<l)..(2<<l)-1; only the accessed path flips
  always_comb begin
    w_upd_bits = r_tree[i_upd_set];
    for (int l = 0; l < WAY_W; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if ((int'(i_upd_way) >> (WAY_W - l)) == k) begin
          w_upd_bits[(1 << l) + k - 1] = ~i_upd_way[WAY_W-1-l];
        end
      end
    end
  end

  always_comb begin
    int v;
    int nxt;
    w_q_bits = r_tree[i_q_set];
    v        = 0;
    nxt      = 0;
    for (int l = 0; l < WAY_W; l++) begin
      nxt = v * 2;
      for (int k = 0; k < (1 << l); k++) begin
        if (k == v && w_q_bits[(1 << l) + k - 1]) begin
          nxt = v * 2 + 1;
        end
      end
      v = nxt;
    end
    o_victim = WAY_W'(v);
  end

  always_ff @(posedge clk) begin
    if (reset || i_clr_all) begin
      for (int s = 0; s < SETS; s++) begin
        r_tree[s] <= '0;
      end
    end else if (i_upd_en) begin
      r_tree[i_upd_set] <= w_upd_bits;
    end
  end

endmodule

// File: rtl/sv32_tlb_cache.sv
// rtl/sv32_tlb_cache.sv - set-associative SV32 TLB with sfence.vma flush FSM; SV32_TLB_STATS_EN adds counters
module sv32_tlb_cache
  import sv32_tlb_pkg::*;
#(
  parameter int VPN_WIDTH     = 20,
  parameter int ASID_WIDTH    = 9,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int SETS          = 16,
  parameter int WAYS          = 4,
  parameter int PTE_G_BIT     = PTE_G_BIT_DFLT
) (
  input logic              clk,
  input logic              reset,
  sv32_tlb_cache_if.slave  bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic                     r_valid [SETS][WAYS];
  logic                     r_g     [SETS][WAYS];
  logic [VPN_WIDTH-1:0]     r_vpn   [SETS][WAYS];
  logic [ASID_WIDTH-1:0]    r_asid  [SETS][WAYS];
  logic [PAYLOAD_WIDTH-1:0] r_pte   [SETS][WAYS];

  fl_state_e             r_state;
  logic [IDX_W-1:0]      r_walk_set;
  logic [ASID_WIDTH-1:0] r_fl_asid;
  logic                  r_busy;
  logic                  r_done;

  logic [IDX_W-1:0] w_lkp_set, w_fill_set, w_inv_set, w_upd_set;
  logic [WAY_W-1:0] w_lkp_way, w_fill_way, w_match_way, w_inv_way, w_plru_victim, w_upd_way;
  logic             w_lkp_match, w_hit, w_fill_match, w_have_inv, w_fill_g;
  logic             w_fl_start, w_inv_all, w_inv_en, w_fill_en, w_upd_en;
  logic [WAYS-1:0]  w_inv_mask;

  assign w_lkp_set  = bus.lkp_vpn[IDX_W-1:0];
  assign w_fill_set = bus.fill_vpn[IDX_W-1:0];
  assign w_fill_g   = bus.fill_pte[PTE_G_BIT];

  // Downward scans so the lowest-index qualifying way is the one left standing
  always_comb begin
    w_lkp_match  = 1'b0;
    w_lkp_way    = '0;
    w_fill_match = 1'b0;
    w_match_way  = '0;
    w_have_inv   = 1'b0;
    w_inv_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_lkp_set][w] && r_vpn[w_lkp_set][w] == bus.lkp_vpn &&
          (r_g[w_lkp_set][w] || r_asid[w_lkp_set][w] == bus.lkp_asid)) begin
        w_lkp_match = 1'b1;
        w_lkp_way   = WAY_W'(w);
      end
      if (r_valid[w_fill_set][w] && r_vpn[w_fill_set][w] == bus.fill_vpn &&
          (r_g[w_fill_set][w] || r_asid[w_fill_set][w] == bus.fill_asid)) begin
        w_fill_match = 1'b1;
        w_match_way  = WAY_W'(w);
      end
      if (!r_valid[w_fill_set][w]) begin
        w_have_inv = 1'b1;
        w_inv_way  = WAY_W'(w);
      end
    end
  end

  assign w_hit       = w_lkp_match && !r_busy;
  assign bus.lkp_hit = w_hit;
  assign bus.lkp_pte = w_hit ? r_pte[w_lkp_set][w_lkp_way] : '0;

  assign w_fill_way = w_fill_match ? w_match_way : (w_have_inv ? w_inv_way : w_plru_victim);

  assign w_fl_start = (r_state == FL_IDLE) && bus.fl_req;
  assign w_inv_all  = w_fl_start && !bus.fl_vpn_en && !bus.fl_asid_en;
  assign w_inv_en   = (w_fl_start && bus.fl_vpn_en) || (r_state == FL_WALK);
  assign w_inv_set  = (r_state == FL_WALK) ? r_walk_set : bus.fl_vpn[IDX_W-1:0];
  assign w_fill_en  = bus.fill_valid && (r_state == FL_IDLE) && !bus.fl_req;

  always_comb begin
    w_inv_mask = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_state == FL_WALK) begin
        w_inv_mask[w] = !r_g[w_inv_set][w] && r_asid[w_inv_set][w] == r_fl_asid;
      end else begin
        w_inv_mask[w] = r_vpn[w_inv_set][w] == bus.fl_vpn &&
                        (!bus.fl_asid_en ||
                         (!r_g[w_inv_set][w] && r_asid[w_inv_set][w] == bus.fl_asid));
      end
    end
  end

  // A fill owns the PLRU port; a same-cycle lookup hit loses its touch
  assign w_upd_en  = w_fill_en || (bus.lkp_valid && w_hit);
  assign w_upd_set = w_fill_en ? w_fill_set : w_lkp_set;
  assign w_upd_way = w_fill_en ? w_fill_way : w_lkp_way;

  tlb_plru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_plru (
    .clk       (clk),
    .reset     (reset),
    .i_clr_all (w_inv_all),
    .i_upd_en  (w_upd_en),
    .i_upd_set (w_upd_set),
    .i_upd_way (w_upd_way),
    .i_q_set   (w_fill_set),
    .o_victim  (w_plru_victim)
  );

  always_ff @(posedge clk) begin
    if (reset || w_inv_all) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
        end
      end
    end else begin
      if (w_inv_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (w_inv_mask[w]) begin
            r_valid[w_inv_set][w] <= 1'b0;
          end
        end
      end
      if (w_fill_en) begin
        r_valid[w_fill_set][w_fill_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      r_vpn[w_fill_set][w_fill_way]  <= bus.fill_vpn;
      r_asid[w_fill_set][w_fill_way] <= w_fill_g ? '0 : bus.fill_asid;
      r_pte[w_fill_set][w_fill_way]  <= bus.fill_pte;
      r_g[w_fill_set][w_fill_way]    <= w_fill_g;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FL_IDLE;
      r_walk_set <= '0;
      r_fl_asid  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        FL_IDLE: begin
          r_done <= 1'b0;
          if (bus.fl_req) begin
            r_fl_asid  <= bus.fl_asid;
            r_walk_set <= '0;
            r_busy     <= 1'b1;
            if (!bus.fl_vpn_en && bus.fl_asid_en) begin
              r_state <= FL_WALK;
            end else begin
              r_state <= FL_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        FL_WALK: begin
          if (r_walk_set == IDX_W'(SETS - 1)) begin
            r_state <= FL_DONE;
            r_done  <= 1'b1;
          end else begin
            r_walk_set <= r_walk_set + 1'b1;
          end
        end
        FL_DONE: begin
          r_state <= FL_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= FL_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fl_busy = r_busy;
  assign bus.fl_done = r_done;

`ifdef SV32_TLB_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (bus.lkp_valid && !r_busy) begin
      if (w_hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
`endif

endmodule
